// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the convolution datapath.
package conv_pkg;

    localparam int unsigned I_PROD_BW = 16;
    localparam int unsigned ACC_LEN   = 32;
    localparam int unsigned O_SUM_BW  = I_PROD_BW + $clog2(ACC_LEN);
    localparam int unsigned LEN_BW    = $clog2(ACC_LEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Out-of-range group lengths (zero or above ACC_LEN) mean a full group.
    function automatic logic [LEN_BW-1:0] eff_len(input logic [LEN_BW-1:0] len);
        if (len == '0 || len > LEN_BW'(ACC_LEN)) begin
            return LEN_BW'(ACC_LEN);
        end
        return len;
    endfunction

endpackage

// File: rtl/psum_accumulator.sv
// Accumulates one group of signed products into a full-precision partial sum,
// with valid/ready on both sides and one result per group.
module psum_accumulator
    import conv_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [I_PROD_BW-1:0] s_prod,
    input  logic [LEN_BW-1:0]    s_len,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [O_SUM_BW-1:0]  m_psum,
    output logic                 o_busy
);

    state_t                state_q;
    logic [O_SUM_BW-1:0]   acc_q;
    logic [O_SUM_BW-1:0]   m_psum_q;
    logic [LEN_BW-1:0]     cnt_q;
    logic [LEN_BW-1:0]     len_q;
    logic                  m_valid_q;

    logic [O_SUM_BW-1:0]   prod_ext;
    logic [O_SUM_BW-1:0]   sum_d;
    logic [LEN_BW-1:0]     cnt_d;
    logic [LEN_BW-1:0]     first_len;
    logic                  take;

    assign prod_ext  = {{(O_SUM_BW - I_PROD_BW){s_prod[I_PROD_BW-1]}}, s_prod};
    assign sum_d     = acc_q + prod_ext;
    assign cnt_d     = cnt_q + LEN_BW'(1);
    assign first_len = eff_len(s_len);

    // While a result is pending, a new beat may only enter when that result retires.
    assign s_ready = (state_q == HOLD) ? m_ready : 1'b1;
    assign take    = s_valid && s_ready;

    assign m_valid = m_valid_q;
    assign m_psum  = m_psum_q;
    assign o_busy  = (state_q != IDLE);

    // Group FSM with counter, accumulator and registered result.
    // IDLE and HOLD share first-beat handling so a pending result can retire in the
    // same cycle the next group starts, giving back-to-back groups without a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            m_psum_q  <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            m_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, HOLD: begin
                    if (take) begin
                        cnt_q <= LEN_BW'(1);
                        acc_q <= prod_ext;
                        len_q <= first_len;
                        if (first_len == LEN_BW'(1)) begin
                            m_psum_q  <= prod_ext;
                            m_valid_q <= 1'b1;
                            state_q   <= HOLD;
                        end else begin
                            m_valid_q <= 1'b0;
                            state_q   <= ACC;
                        end
                    end else if (state_q == HOLD && m_ready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                ACC: begin
                    if (s_valid) begin
                        cnt_q <= cnt_d;
                        acc_q <= sum_d;
                        if (cnt_d == len_q) begin
                            m_psum_q  <= sum_d;
                            m_valid_q <= 1'b1;
                            state_q   <= HOLD;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
